// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel fetch path.
// The fetch FSM encoding is visible on the fetch_state debug port.
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 8;
    localparam int WORD_W       = PIX_PER_WORD * PIX_W;

    // Number of SRAM words that hold one full frame of packed pixels.
    function automatic int frame_words(input int h_active, input int v_active);
        return (h_active * v_active) / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/vga_word_fifo.sv
// Small synchronous word FIFO with a synchronous flush and a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module vga_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_MAX);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Prefetches framebuffer words from SRAM into a word FIFO and hands them to the
// VGA stage one byte-wide pixel per pixel_req, restarting on every frame_start.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          H_ACTIVE   = H_ACTIVE_DEF,
    parameter int          V_ACTIVE   = V_ACTIVE_DEF,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        frame_start,
    input  logic        pixel_req,
    output logic [7:0]  pixel_data,
    output logic        pixel_valid,
    output logic        underflow,
    output logic        sram_rd_en,
    output logic [31:0] sram_addr,
    input  logic        sram_busy,
    input  logic [31:0] sram_rdata,
    output logic [2:0]  fetch_state
);

    localparam int FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
    // One extra code so the counter can sit at FRAME_WORDS without wrapping.
    localparam int WCNT_W = $clog2(FRAME_WORDS + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BIDX_W = $clog2(PIX_PER_WORD);

    localparam logic [WCNT_W-1:0] FRAME_WORDS_C = WCNT_W'(FRAME_WORDS);
    localparam logic [WCNT_W-1:0] WCNT_ONE      = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  FIFO_DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [BIDX_W-1:0] LAST_BYTE     = BIDX_W'(PIX_PER_WORD - 1);
    localparam logic [BIDX_W-1:0] BIDX_ONE      = BIDX_W'(1);

    fetch_state_t      state_q, state_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic              underflow_q, underflow_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    vga_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (frame_start),
        .wdata_i (sram_rdata),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            underflow_q <= underflow_d;
        end
    end

    // Fetch FSM: one read outstanding at a time, issued only when a FIFO slot is free.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        fifo_push  = 1'b0;

        if (frame_start) begin
            word_cnt_d = '0;
            // A read still in flight must be absorbed before the next frame's first request.
            state_d    = (state_q == WAIT || state_q == DRAIN) ? DRAIN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (word_cnt_q == FRAME_WORDS_C) begin
                        state_d = DONE;
                    end else if (fifo_count < FIFO_DEPTH_C) begin
                        state_d = REQ;
                    end
                end
                REQ: state_d = WAIT;
                WAIT: begin
                    if (!sram_busy) begin
                        fifo_push  = !fifo_full;
                        word_cnt_d = word_cnt_q + WCNT_ONE;
                        state_d    = IDLE;
                    end
                end
                DONE: state_d = DONE;
                DRAIN: begin
                    if (!sram_busy) begin
                        word_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pixel unpack: little-endian bytes, head word popped after its last byte.
    always_comb begin
        byte_idx_d  = byte_idx_q;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;

        if (frame_start) begin
            byte_idx_d  = '0;
            underflow_d = 1'b0;
        end else if (pixel_req) begin
            if (!fifo_empty) begin
                byte_idx_d = byte_idx_q + BIDX_ONE;
                fifo_pop   = (byte_idx_q == LAST_BYTE);
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    assign pixel_valid = !fifo_empty;
    assign pixel_data  = fifo_empty ? '0 : fifo_head[{byte_idx_q, 3'b000} +: PIX_W];
    assign underflow   = underflow_q;
    assign sram_rd_en  = (state_q == REQ);
    assign sram_addr   = sram_rd_en ? (BASE_ADDR + 32'(word_cnt_q)) : '0;
    assign fetch_state = state_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: SRAM responder models, expected pixel and
// address queues, and one task per scenario.
module tb_vga_pixel_fetch;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] DATA0 = 32'hDDCC_BBAA;
    localparam logic [31:0] EDATA = 32'h1122_3344;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        nrst = 1'b0;
    logic        frame_start = 1'b0;
    logic        pixel_req = 1'b0;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        underflow;
    logic        sram_rd_en;
    logic [31:0] sram_addr;
    logic        sram_busy = 1'b0;
    logic [31:0] sram_rdata = '0;
    logic [2:0]  fetch_state;

    logic        e_frame_start = 1'b0;
    logic        e_pixel_req = 1'b0;
    logic [7:0]  e_pixel_data;
    logic        e_pixel_valid;
    logic        e_underflow;
    logic        e_sram_rd_en;
    logic [31:0] e_sram_addr;
    logic        e_sram_busy = 1'b0;
    logic [31:0] e_sram_rdata = '0;
    logic [2:0]  e_fetch_state;

    int n_vec = 0;
    int n_err = 0;

    int          lat = 0;
    bit          hold_busy = 1'b0;
    bit          pend = 1'b0;
    bit          ret_valid = 1'b0;
    bit          discard = 1'b0;
    int          cnt = 0;
    logic [31:0] addr_l = '0;
    bit          e_pend = 1'b0;
    logic [31:0] e_addr_l = '0;

    logic [31:0] obs_addr_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] e_obs_q[$];
    logic [7:0]  exp_pix_q[$];

    vga_pixel_fetch #(.BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .frame_start (frame_start),
        .pixel_req   (pixel_req),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .underflow   (underflow),
        .sram_rd_en  (sram_rd_en),
        .sram_addr   (sram_addr),
        .sram_busy   (sram_busy),
        .sram_rdata  (sram_rdata),
        .fetch_state (fetch_state)
    );

    vga_pixel_fetch #(.H_ACTIVE(8), .V_ACTIVE(2)) dut_eof (
        .clk         (clk),
        .nrst        (nrst),
        .frame_start (e_frame_start),
        .pixel_req   (e_pixel_req),
        .pixel_data  (e_pixel_data),
        .pixel_valid (e_pixel_valid),
        .underflow   (e_underflow),
        .sram_rd_en  (e_sram_rd_en),
        .sram_addr   (e_sram_addr),
        .sram_busy   (e_sram_busy),
        .sram_rdata  (e_sram_rdata),
        .fetch_state (e_fetch_state)
    );

    // SRAM responder: busy for 'lat' cycles after a request, data on the first busy=0 cycle.
    always @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            sram_busy = 1'b0;
            pend      = 1'b0;
            ret_valid = 1'b0;
            cnt       = 0;
        end else begin
            ret_valid = 1'b0;
            if (pend) begin
                if (hold_busy) begin
                    sram_busy = 1'b1;
                end else if (cnt == 0) begin
                    sram_busy  = 1'b0;
                    sram_rdata = DATA0 + (addr_l - BASE);
                    pend       = 1'b0;
                    ret_valid  = 1'b1;
                end else begin
                    cnt       = cnt - 1;
                    sram_busy = 1'b1;
                end
            end
            if (sram_rd_en) begin
                pend      = 1'b1;
                cnt       = lat;
                sram_busy = 1'b1;
                addr_l    = sram_addr;
                obs_addr_q.push_back(sram_addr);
            end
        end
    end

    // Expected pixel stream: bytes of every returned word that is not swallowed by a frame restart.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_pix_q.delete();
            discard = 1'b0;
        end else if (frame_start) begin
            exp_pix_q.delete();
            discard = pend;
        end else if (ret_valid) begin
            if (discard) begin
                discard = 1'b0;
            end else begin
                for (int b = 0; b < 4; b++) exp_pix_q.push_back(sram_rdata[8*b +: 8]);
            end
        end
    end

    // Zero-latency responder for the small-frame instance.
    always @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            e_sram_busy = 1'b0;
            e_pend      = 1'b0;
        end else begin
            if (e_pend) begin
                e_sram_busy  = 1'b0;
                e_sram_rdata = EDATA + e_addr_l;
                e_pend       = 1'b0;
            end
            if (e_sram_rd_en) begin
                e_pend      = 1'b1;
                e_sram_busy = 1'b1;
                e_addr_l    = e_sram_addr;
                e_obs_q.push_back(e_sram_addr);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; frame_start = 1'b0; pixel_req = 1'b0;
        e_frame_start = 1'b0; e_pixel_req = 1'b0; lat = 0; hold_busy = 1'b0;
        step(2);
        n_vec++;
        if ({pixel_data, pixel_valid, underflow, sram_rd_en, sram_addr} !== 43'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pixel_data, pixel_valid, underflow, sram_rd_en, sram_addr});
        end
        n_vec++;
        if (fetch_state !== 3'd0) begin
            n_err++; $display("FAIL reset_state: got %0d expected 0", fetch_state);
        end
        obs_addr_q.delete();
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sram_rd_en) break;
        end
        n_vec++;
        if (sram_rd_en !== 1'b1 || sram_addr !== BASE) begin
            n_err++;
            $display("FAIL first_req: got en=%b addr=%h expected en=1 addr=%h", sram_rd_en, sram_addr, BASE);
        end
        step(1);
        n_vec++;
        if (sram_rd_en !== 1'b0) begin
            n_err++; $display("FAIL req_one_cycle: got en=%b expected 0", sram_rd_en);
        end
    endtask

    task automatic test_fill();
        logic [31:0] o;
        logic [31:0] e;
        nrst = 1'b0; lat = 2; hold_busy = 1'b0;
        step(2);
        obs_addr_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < 8; i++) exp_addr_q.push_back(BASE + 32'(i));
        nrst = 1'b1;
        step(80);
        n_vec++;
        if (obs_addr_q.size() != 8) begin
            n_err++; $display("FAIL fill_req_count: got %0d expected 8", obs_addr_q.size());
        end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
            n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL fill_addr: got %h expected %h", o, e);
            end
        end
        obs_addr_q.delete();
        step(20);
        n_vec++;
        if (obs_addr_q.size() != 0 || pixel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full_idle: got reqs=%0d valid=%b expected reqs=0 valid=1",
                     obs_addr_q.size(), pixel_valid);
        end
    endtask

    task automatic test_unpack();
        logic [7:0]  eb;
        logic [31:0] o;
        obs_addr_q.delete();
        exp_addr_q.delete();
        exp_addr_q.push_back(BASE + 32'd8);
        for (int i = 0; i < 5; i++) begin
            eb = (exp_pix_q.size() > 0) ? exp_pix_q.pop_front() : 'x;
            n_vec++;
            if ({pixel_valid, pixel_data} !== {1'b1, eb}) begin
                n_err++;
                $display("FAIL unpack_pixel[%0d]: got v=%b d=%h expected v=1 d=%h", i, pixel_valid, pixel_data, eb);
            end
            pixel_req = 1'b1;
            step(1);
        end
        pixel_req = 1'b0;
        step(20);
        n_vec++;
        if (obs_addr_q.size() != 1) begin
            n_err++; $display("FAIL refill_count: got %0d expected 1", obs_addr_q.size());
        end
        o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
        n_vec++;
        if (o !== exp_addr_q[0]) begin
            n_err++; $display("FAIL refill_addr: got %h expected %h", o, exp_addr_q[0]);
        end
    endtask

    task automatic test_underflow();
        int n;
        logic [7:0] eb;
        hold_busy = 1'b1;
        n = exp_pix_q.size();
        for (int i = 0; i < n; i++) begin
            eb = exp_pix_q.pop_front();
            n_vec++;
            if ({pixel_valid, pixel_data} !== {1'b1, eb}) begin
                n_err++;
                $display("FAIL drain_pixel[%0d]: got v=%b d=%h expected v=1 d=%h", i, pixel_valid, pixel_data, eb);
            end
            pixel_req = 1'b1;
            step(1);
        end
        pixel_req = 1'b0;
        n_vec++;
        if ({pixel_valid, pixel_data, underflow, fetch_state} !== {1'b0, 8'h00, 1'b0, 3'd2}) begin
            n_err++;
            $display("FAIL empty_state: got v=%b d=%h uf=%b st=%0d expected v=0 d=00 uf=0 st=2",
                     pixel_valid, pixel_data, underflow, fetch_state);
        end
        pixel_req = 1'b1;
        step(1);
        pixel_req = 1'b0;
        n_vec++;
        if (underflow !== 1'b1) begin
            n_err++; $display("FAIL underflow_set: got %b expected 1", underflow);
        end
        step(5);
        n_vec++;
        if (underflow !== 1'b1 || pixel_valid !== 1'b0) begin
            n_err++; $display("FAIL underflow_sticky: got uf=%b v=%b expected uf=1 v=0", underflow, pixel_valid);
        end
    endtask

    task automatic test_frame_drain();
        obs_addr_q.delete();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        n_vec++;
        if ({fetch_state, underflow, pixel_valid} !== {3'd4, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL drain_enter: got st=%0d uf=%b v=%b expected st=4 uf=0 v=0", fetch_state, underflow, pixel_valid);
        end
        hold_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sram_rd_en) break;
        end
        n_vec++;
        if ({sram_rd_en, pixel_valid, sram_addr} !== {1'b1, 1'b0, BASE}) begin
            n_err++;
            $display("FAIL drain_restart: got en=%b v=%b addr=%h expected en=1 v=0 addr=%h",
                     sram_rd_en, pixel_valid, sram_addr, BASE);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eb;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            if (pixel_valid) break;
            step(1);
        end
        for (int i = 0; i < 60; i++) begin
            eb = (exp_pix_q.size() > 0) ? exp_pix_q.pop_front() : 'x;
            n_vec++;
            if ({pixel_valid, pixel_data} !== {1'b1, eb}) begin
                n_err++;
                $display("FAIL stream_pixel[%0d]: got v=%b d=%h expected v=1 d=%h", i, pixel_valid, pixel_data, eb);
            end
            pixel_req = 1'b1;
            step(1);
        end
        pixel_req = 1'b0;
        n_vec++;
        if (underflow !== 1'b0) begin
            n_err++; $display("FAIL stream_no_underflow: got %b expected 0", underflow);
        end
    endtask

    task automatic test_end_of_frame();
        logic [31:0] o;
        logic [31:0] e;
        nrst = 1'b0; hold_busy = 1'b0; lat = 0;
        step(2);
        e_obs_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(i));
        nrst = 1'b1;
        step(30);
        n_vec++;
        if (e_obs_q.size() != 4) begin
            n_err++; $display("FAIL eof_req_count: got %0d expected 4", e_obs_q.size());
        end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (e_obs_q.size() > 0) ? e_obs_q.pop_front() : 'x;
            n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL eof_addr: got %h expected %h", o, e);
            end
        end
        n_vec++;
        if ({e_fetch_state, e_pixel_valid} !== {3'd3, 1'b1}) begin
            n_err++; $display("FAIL eof_done: got st=%0d v=%b expected st=3 v=1", e_fetch_state, e_pixel_valid);
        end
        e_obs_q.delete();
        step(50);
        n_vec++;
        if (e_obs_q.size() != 0 || e_fetch_state !== 3'd3) begin
            n_err++;
            $display("FAIL eof_quiet: got reqs=%0d st=%0d expected reqs=0 st=3", e_obs_q.size(), e_fetch_state);
        end
        e_frame_start = 1'b1;
        step(1);
        e_frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (e_sram_rd_en) break;
            step(1);
        end
        n_vec++;
        if ({e_sram_rd_en, e_sram_addr, e_pixel_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL eof_restart: got en=%b addr=%h v=%b expected en=1 addr=0 v=0",
                     e_sram_rd_en, e_sram_addr, e_pixel_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_unpack();
        test_underflow();
        test_frame_drain();
        test_back_to_back();
        test_end_of_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
